lfsr_rng_sched: RTL and testbench
=================================

// Module: lfsr_rng_sched
// PURPOSE
// Round-robin scheduler sharing one lfsr instance among NUM_REQ requesters.
// - On a granted request, clocks the LFSR for WORD_BITS cycles and serially
//   collects its LSB into a WORD_BITS-bit random word.
// - Returns the word to the winning requester with a one-cycle valid pulse.
// - Sits beside the lfsr in the crypto block and is the only driver of its
//   enable input.
// PARAMETERS
// NUM_REQ    2   number of requesters (>=2); pointer width = clog2(NUM_REQ)
// WORD_BITS  16  random word width (>=2); counter width = clog2(WORD_BITS+1)
// PORTS
// clk        in   1          system clock
// reset      in   1          synchronous, active-high reset
// req        in   NUM_REQ    level request per requester
// gnt        out  NUM_REQ    one-hot grant; held from GEN entry through DONE
// rnd_valid  out  1          one-cycle pulse: rnd_data valid for gnt owner
// rnd_data   out  WORD_BITS  assembled random word
// busy       out  1          high in GEN or DONE
// lfsr_en    out  1          enable to the lfsr instance
// lfsr_lsb   in   1          lfsr data_out[0]
// BEHAVIOUR
// Reset values: gnt=0, rnd_valid=0, rnd_data=0, busy=0, lfsr_en=0,
//   rr_ptr=0, bit_cnt=0, state=IDLE.
// - reset wins over every other event, including mid-GEN.
// - The lfsr shares the same reset and restarts from its init value.
// States: IDLE, GEN, DONE.
// IDLE:
// - If req!=0, pick the first asserted req at or after rr_ptr, wrapping modulo
//   NUM_REQ.
// - Register gnt=onehot(winner), set bit_cnt=0, go to GEN.
// - If req==0, stay in IDLE.
// GEN:
// - Combinationally assert lfsr_en=1 every cycle.
// - Sample lfsr_lsb in the same cycle, i.e. the pre-shift value:
//   shreg <= {shreg[WORD_BITS-2:0], lfsr_lsb}.
// - The first sampled bit ends up in the MSB.
// - bit_cnt increments each cycle; after the WORD_BITS-th sample, go to DONE.
// - If req[winner] drops during GEN: go to IDLE next cycle and drop gnt.
//   lfsr_en is still 1 in that cycle. Discard the partial word; rr_ptr and
//   rnd_data are unchanged. The LFSR state advanced and is NOT rewound.
// DONE (one cycle):
// - rnd_valid=1, rnd_data=shreg, gnt still asserted, lfsr_en=0.
// - rr_ptr <= (winner+1) mod NUM_REQ; go to IDLE with gnt=0.
// - rnd_data holds its value until the next DONE.
// Timing: req seen in IDLE at cycle t gives GEN t+1..t+WORD_BITS and
//   rnd_valid at t+WORD_BITS+1. Back-to-back service period is WORD_BITS+2.
// Requester protocol: hold req until it sees gnt[i]&rnd_valid, then drop req
//   or keep it high for another word.
// Changes to req for non-granted requesters during GEN/DONE are ignored until
//   the next IDLE.
// lfsr_en is never asserted outside GEN: exactly WORD_BITS pulses per
//   completed word.
// TESTING (NUM_REQ=2, WORD_BITS=8, lfsr POLY=8'b11000001, INIT=7'b1111010)
// 1 reset, req=2'b01 -> gnt=01 from cycle 1; lfsr_en high 8 cycles;
//   rnd_valid pulse with rnd_data=8'h0E; rr_ptr=1.
// 2 req=2'b11 held from reset -> grants alternate 01,10,01,...; rnd_valid
//   every 10 cycles; 2nd word continues the LFSR stream.
// 3 req=2'b01, drop req[0] after 3 GEN cycles -> IDLE, gnt=0, no rnd_valid,
//   rnd_data unchanged, rr_ptr=0.
// 4 assert reset during GEN cycle 5 -> all outputs 0 next cycle; repeat
//   test 1 -> rnd_data=8'h0E again.
// 5 req=2'b10 only from reset (rr_ptr=0) -> gnt=10 (wrap search); after
//   DONE rr_ptr=0.
// 6 random req over 10k cycles -> gnt one-hot or 0; lfsr_en only in GEN;
//   no requester waits >2 service periods.

Source files
------------

// File: rtl/lfsr_rng_sched.sv
// lfsr_rng_sched: round-robin scheduler that lends one shared LFSR to
// NUM_REQ requesters. A granted requester gets a WORD_BITS-bit word built
// by clocking the LFSR WORD_BITS times and collecting its LSB serially,
// delivered with a one-cycle rnd_valid pulse while its grant is still held.
module lfsr_rng_sched #(
  parameter int NUM_REQ   = 2,
  parameter int WORD_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 rnd_valid,
  output logic [WORD_BITS-1:0] rnd_data,
  output logic                 busy,
  output logic                 lfsr_en,
  input  logic                 lfsr_lsb
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(WORD_BITS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state;
  logic [PTR_W-1:0]     rr_ptr;    // search start for the next arbitration
  logic [PTR_W-1:0]     win_idx;   // index of the requester being served
  logic [CNT_W-1:0]     bit_cnt;   // samples taken so far in this word
  // Holds the first WORD_BITS-1 samples; the final sample is concatenated
  // straight into rnd_data, so no storage bit ever goes unread.
  logic [WORD_BITS-2:0] shreg;
  logic [WORD_BITS-1:0] next_word;

  logic                 pick_any;
  logic [PTR_W-1:0]     pick_idx;

  // (base + off) mod NUM_REQ, narrowed back to pointer width.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base,
                                                input int               off);
    return PTR_W'((int'(base) + off) % NUM_REQ);
  endfunction

  // Round-robin search: first asserted request at or after rr_ptr, wrapping.
  always_comb begin
    // NOTE: every signal driven here gets a default before any conditional
    // assignment, so no path can leave it holding a value (no latch).
    pick_any = 1'b0;
    pick_idx = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      if (!pick_any && req[wrap_add(rr_ptr, off)]) begin
        pick_any = 1'b1;
        pick_idx = wrap_add(rr_ptr, off);
      end
    end
  end

  // Word as it stands once the current (pre-shift) LFSR bit is appended;
  // the first sample ends up in the MSB.
  assign next_word = {shreg, lfsr_lsb};

  // The LFSR is clocked in every GEN cycle, including the cycle in which an
  // abort is detected; it is never rewound.
  assign lfsr_en = (state == GEN);

  // Scheduler FSM: arbitration, bit collection, word delivery and abort.
  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values and the update order inside the block is moot.
    if (reset) begin
      state     <= IDLE;
      gnt       <= '0;
      rnd_valid <= 1'b0;
      rnd_data  <= '0;
      busy      <= 1'b0;
      rr_ptr    <= '0;
      win_idx   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          rnd_valid <= 1'b0;
          bit_cnt   <= '0;
          if (pick_any) begin
            gnt     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            win_idx <= pick_idx;
            busy    <= 1'b1;
            state   <= GEN;
          end
        end

        GEN: begin
          if (!req[win_idx]) begin
            // Requester withdrew: drop the partial word, keep rr_ptr and
            // rnd_data as they were.
            gnt     <= '0;
            busy    <= 1'b0;
            bit_cnt <= '0;
            state   <= IDLE;
          end else begin
            shreg   <= next_word[WORD_BITS-2:0];
            bit_cnt <= bit_cnt + CNT_W'(1);
            if (bit_cnt == CNT_W'(WORD_BITS - 1)) begin
              rnd_data  <= next_word;
              rnd_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end

        DONE: begin
          rnd_valid <= 1'b0;
          gnt       <= '0;
          busy      <= 1'b0;
          rr_ptr    <= wrap_add(win_idx, 1);
          state     <= IDLE;
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_rng_sched.sv
// Bench for lfsr_rng_sched (NUM_REQ=2, WORD_BITS=8) driving a behavioural
// model of the shared 7-bit LFSR (x^7+x^6+1, init 7'b1111010). A negedge
// monitor keeps a scoreboard: the expected owner and word are pushed when a
// grant starts and popped when rnd_valid appears.
module tb_lfsr_rng_sched;

  localparam int NREQ   = 2;
  localparam int WBITS  = 8;
  localparam int PERIOD = WBITS + 2;
  localparam logic [6:0] LFSR_INIT = 7'b1111010;

  logic              clk;
  logic              reset;
  logic [NREQ-1:0]   req;
  logic [NREQ-1:0]   gnt;
  logic              rnd_valid;
  logic [WBITS-1:0]  rnd_data;
  logic              busy;
  logic              lfsr_en;
  logic              lfsr_lsb;

  logic [6:0]        lfsr_q;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    logic [NREQ-1:0]  gnt;
    logic [WBITS-1:0] word;
  } exp_t;

  exp_t            sb_q[$];
  exp_t            mon_e;
  logic [6:0]      ref_state;
  int              ptr_model;
  logic [NREQ-1:0] prev_gnt;
  logic [NREQ-1:0] prev_req;
  logic            prev_valid;
  int              en_cnt;
  int              abort_cnt     = 0;
  int              last_abort_en = 0;
  int              words_done    = 0;
  int              wait_cnt [NREQ];

  lfsr_rng_sched #(
    .NUM_REQ   (NREQ),
    .WORD_BITS (WBITS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .gnt       (gnt),
    .rnd_valid (rnd_valid),
    .rnd_data  (rnd_data),
    .busy      (busy),
    .lfsr_en   (lfsr_en),
    .lfsr_lsb  (lfsr_lsb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Shared LFSR: left shift, feedback into bit 0, same synchronous reset.
  always @(posedge clk) begin
    if (reset)        lfsr_q <= LFSR_INIT;
    else if (lfsr_en) lfsr_q <= {lfsr_q[5:0], lfsr_q[6] ^ lfsr_q[5]};
  end
  assign lfsr_lsb = lfsr_q[0];

  function automatic logic [6:0] lfsr_step(input logic [6:0] s);
    return {s[5:0], s[6] ^ s[5]};
  endfunction

  function automatic logic [6:0] lfsr_advance(input logic [6:0] s, input int n);
    logic [6:0] t;
    t = s;
    for (int i = 0; i < n; i++) t = lfsr_step(t);
    return t;
  endfunction

  // Word produced by WBITS LSB samples from state s, first sample in MSB.
  function automatic logic [WBITS-1:0] lfsr_word(input logic [6:0] s);
    logic [WBITS-1:0] w;
    logic [6:0]       t;
    w = '0;
    t = s;
    for (int i = 0; i < WBITS; i++) begin
      w = {w[WBITS-2:0], t[0]};
      t = lfsr_step(t);
    end
    return w;
  endfunction

  function automatic logic [NREQ-1:0] rr_pick(input logic [NREQ-1:0] r, input int ptr);
    logic [NREQ-1:0] g;
    int idx;
    g = '0;
    for (int off = NREQ - 1; off >= 0; off--) begin
      idx = (ptr + off) % NREQ;
      if (r[idx]) begin
        g = '0;
        g[idx] = 1'b1;
      end
    end
    return g;
  endfunction

  // Monitor: invariants every cycle, scoreboard push on grant start,
  // pop/compare on rnd_valid, abort bookkeeping and wait bounds.
  always @(negedge clk) begin
    if (reset) begin
      sb_q.delete();
      ref_state  = LFSR_INIT;
      ptr_model  = 0;
      prev_gnt   = '0;
      prev_req   = req;
      prev_valid = 1'b0;
      en_cnt     = 0;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] = 0;
    end else begin
      checks++;
      if (!$onehot0(gnt)) begin
        failures++;
        $display("FAIL gnt_onehot: gnt=%b, required one-hot or zero", gnt);
      end
      checks++;
      if (lfsr_en && !(busy && !rnd_valid)) begin
        failures++;
        $display("FAIL lfsr_en_outside_gen: lfsr_en=%b busy=%b rnd_valid=%b", lfsr_en, busy, rnd_valid);
      end
      checks++;
      if (busy !== (gnt != '0)) begin
        failures++;
        $display("FAIL busy_vs_gnt: busy=%b gnt=%b, required busy == |gnt", busy, gnt);
      end

      if (prev_gnt == '0 && gnt != '0) begin
        mon_e.gnt  = rr_pick(prev_req, ptr_model);
        mon_e.word = lfsr_word(ref_state);
        ref_state  = lfsr_advance(ref_state, WBITS);
        checks++;
        if (gnt !== mon_e.gnt) begin
          failures++;
          $display("FAIL grant_owner: gnt=%b required %b (req was %b)", gnt, mon_e.gnt, prev_req);
        end
        sb_q.push_back(mon_e);
        en_cnt = 0;
      end

      if (lfsr_en) en_cnt++;

      if (rnd_valid) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_valid: rnd_valid=1 with no outstanding grant, gnt=%b", gnt);
        end else begin
          mon_e = sb_q.pop_front();
          if (gnt !== mon_e.gnt) begin
            failures++;
            $display("FAIL valid_owner: gnt=%b required %b", gnt, mon_e.gnt);
          end
          checks++;
          if (rnd_data !== mon_e.word) begin
            failures++;
            $display("FAIL word_data: rnd_data=%h required %h", rnd_data, mon_e.word);
          end
          checks++;
          if (en_cnt != WBITS) begin
            failures++;
            $display("FAIL en_pulses: lfsr_en pulses=%0d required %0d", en_cnt, WBITS);
          end
          words_done++;
          for (int i = 0; i < NREQ; i++) if (mon_e.gnt[i]) ptr_model = (i + 1) % NREQ;
        end
      end

      if (prev_gnt != '0 && gnt == '0 && !prev_valid) begin
        abort_cnt++;
        last_abort_en = en_cnt;
        if (sb_q.size() > 0) mon_e = sb_q.pop_front();
      end

      for (int i = 0; i < NREQ; i++) begin
        if (req[i] && !gnt[i]) wait_cnt[i]++;
        else                   wait_cnt[i] = 0;
        checks++;
        if (wait_cnt[i] > 2 * PERIOD) begin
          failures++;
          $display("FAIL fairness: requester %0d waited %0d cycles, limit %0d", i, wait_cnt[i], 2 * PERIOD);
          wait_cnt[i] = 0;
        end
      end

      prev_gnt   = gnt;
      prev_req   = req;
      prev_valid = rnd_valid;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = '0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic wait_valid(input int budget, output int n);
    n = 0;
    while (!rnd_valid && n < budget) begin
      tick(1);
      n++;
    end
    checks++;
    if (!rnd_valid) begin
      failures++;
      $display("FAIL valid_timeout: no rnd_valid within %0d cycles", budget);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s_drain: %0d words outstanding, required 0", name, sb_q.size());
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({gnt, rnd_valid, rnd_data, busy, lfsr_en} !== '0) begin
      failures++;
      $display("FAIL %s: gnt=%b rnd_valid=%b rnd_data=%h busy=%b lfsr_en=%b, required all 0",
               name, gnt, rnd_valid, rnd_data, busy, lfsr_en);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = 2'b01;
    tick(2);
    check_all_zero("reset_values");
    req   = '0;
    reset = 1'b0;
    tick(3);
    check_all_zero("idle_no_req");
  endtask

  task automatic test_single();
    int n;
    do_reset();
    req = 2'b01;
    tick(1);
    checks++;
    if (gnt !== 2'b01 || busy !== 1'b1 || lfsr_en !== 1'b1) begin
      failures++;
      $display("FAIL single_grant: gnt=%b busy=%b lfsr_en=%b, required 01/1/1", gnt, busy, lfsr_en);
    end
    wait_valid(WBITS + 4, n);
    checks++;
    if (n != WBITS) begin
      failures++;
      $display("FAIL single_latency: rnd_valid after %0d GEN cycles, required %0d", n, WBITS);
    end
    checks++;
    if (rnd_data !== 8'h0E || gnt !== 2'b01) begin
      failures++;
      $display("FAIL single_word: rnd_data=%h gnt=%b, required 0e/01", rnd_data, gnt);
    end
    req = '0;
    tick(1);
    checks++;
    if (rnd_valid !== 1'b0 || gnt !== '0 || rnd_data !== 8'h0E || lfsr_en !== 1'b0) begin
      failures++;
      $display("FAIL single_after_done: rnd_valid=%b gnt=%b rnd_data=%h lfsr_en=%b, required 0/00/0e/0",
               rnd_valid, gnt, rnd_data, lfsr_en);
    end
    req = 2'b11;
    tick(1);
    checks++;
    if (gnt !== 2'b10) begin
      failures++;
      $display("FAIL single_rr_ptr: gnt=%b, required 10 after requester 0 served", gnt);
    end
    wait_valid(WBITS + 4, n);
    req = '0;
    tick(2);
    check_drained("single");
  endtask

  task automatic test_back_to_back();
    int n;
    int c_prev;
    logic [NREQ-1:0] exp_g;
    do_reset();
    req = 2'b11;
    wait_valid(PERIOD + 4, n);
    c_prev = cyc;
    checks++;
    if (gnt !== 2'b01) begin
      failures++;
      $display("FAIL b2b_grant0: gnt=%b required 01", gnt);
    end
    for (int k = 1; k < 4; k++) begin
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      tick(1);
      wait_valid(PERIOD + 4, n);
      checks++;
      if (gnt !== exp_g) begin
        failures++;
        $display("FAIL b2b_grant%0d: gnt=%b required %b", k, gnt, exp_g);
      end
      checks++;
      if (cyc - c_prev != PERIOD) begin
        failures++;
        $display("FAIL b2b_period%0d: period=%0d required %0d", k, cyc - c_prev, PERIOD);
      end
      c_prev = cyc;
    end
    req = '0;
    tick(2);
    check_drained("b2b");
  endtask

  task automatic test_abort();
    int n;
    int aborts_before;
    logic [WBITS-1:0] exp_w;
    do_reset();
    aborts_before = abort_cnt;
    req = 2'b01;
    tick(1);
    tick(3);
    req = '0;
    checks++;
    if (lfsr_en !== 1'b1) begin
      failures++;
      $display("FAIL abort_en_held: lfsr_en=%b in the withdrawing GEN cycle, required 1", lfsr_en);
    end
    tick(1);
    check_all_zero("abort_idle");
    tick(1);
    checks++;
    if (abort_cnt != aborts_before + 1 || last_abort_en != 4) begin
      failures++;
      $display("FAIL abort_count: aborts=%0d en_pulses=%0d, required %0d and 4",
               abort_cnt - aborts_before, last_abort_en, 1);
    end
    ref_state = lfsr_advance(LFSR_INIT, 4);
    exp_w     = lfsr_word(lfsr_advance(LFSR_INIT, 4));
    req = 2'b11;
    tick(1);
    checks++;
    if (gnt !== 2'b01) begin
      failures++;
      $display("FAIL abort_rr_ptr: gnt=%b, required 01 (pointer unchanged)", gnt);
    end
    wait_valid(WBITS + 4, n);
    checks++;
    if (rnd_data !== exp_w) begin
      failures++;
      $display("FAIL abort_no_rewind: rnd_data=%h required %h", rnd_data, exp_w);
    end
    req = '0;
    tick(2);
    check_drained("abort");
  endtask

  task automatic test_reset_mid_gen();
    int n;
    do_reset();
    req = 2'b01;
    tick(1);
    tick(4);
    reset = 1'b1;
    tick(1);
    check_all_zero("reset_mid_gen");
    req   = '0;
    reset = 1'b0;
    req   = 2'b01;
    tick(1);
    wait_valid(WBITS + 4, n);
    checks++;
    if (rnd_data !== 8'h0E) begin
      failures++;
      $display("FAIL reset_restart_word: rnd_data=%h required 0e", rnd_data);
    end
    req = '0;
    tick(2);
    check_drained("reset_mid");
  endtask

  task automatic test_wrap();
    int n;
    do_reset();
    req = 2'b10;
    tick(1);
    checks++;
    if (gnt !== 2'b10) begin
      failures++;
      $display("FAIL wrap_grant: gnt=%b required 10", gnt);
    end
    wait_valid(WBITS + 4, n);
    checks++;
    if (rnd_data !== 8'h0E) begin
      failures++;
      $display("FAIL wrap_word: rnd_data=%h required 0e", rnd_data);
    end
    req = 2'b11;
    tick(2);
    checks++;
    if (gnt !== 2'b01) begin
      failures++;
      $display("FAIL wrap_rr_ptr: gnt=%b, required 01 (pointer wrapped to 0)", gnt);
    end
    wait_valid(WBITS + 4, n);
    req = '0;
    tick(2);
    check_drained("wrap");
  endtask

  task automatic test_random();
    int words_before;
    int guard;
    do_reset();
    words_before = words_done;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) begin
          if ($urandom_range(3) == 0) req[i] = 1'b1;
        end else if (gnt[i] && rnd_valid && $urandom_range(1) == 0) begin
          req[i] = 1'b0;
        end
      end
      tick(1);
    end
    guard = 0;
    while (req != '0 && guard < 200) begin
      for (int i = 0; i < NREQ; i++) if (req[i] && gnt[i] && rnd_valid) req[i] = 1'b0;
      tick(1);
      guard++;
    end
    checks++;
    if (req != '0) begin
      failures++;
      $display("FAIL random_drain_timeout: req=%b still pending after %0d cycles", req, guard);
    end
    req = '0;
    tick(3);
    check_drained("random");
    checks++;
    if (words_done - words_before < 500) begin
      failures++;
      $display("FAIL random_throughput: %0d words delivered, required at least 500", words_done - words_before);
    end
  endtask

  initial begin
    #(3000000);
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    req   = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_abort();
    test_reset_mid_gen();
    test_wrap();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
